// File: rtl/xillybus_wrapper_mul_arbiter.sv
// Round-robin arbiter sharing one pipelined 15x15 multiplier among
// NUM_REQ requesters; results return tagged with the requester id.
//
// Ports:
//   ap_clk, ap_rst_n      clock, synchronous active-low reset
//   cfg_enable            1 = grant new requests, 0 = drain only
//   req_valid/req_ready   per-requester handshake (ready one-hot or zero)
//   req_a, req_b          packed operands, requester i at slice i
//   rsp_valid/rsp_ready   result handshake; stall freezes the pipe
//   rsp_id, rsp_p         issuing requester and signed product
//   busy                  any pipeline stage holds a valid op
module xillybus_wrapper_mul_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int ID_WIDTH    = 2,
  parameter int MUL_LATENCY = 3,
  parameter int A_WIDTH     = 15,
  parameter int B_WIDTH     = 15,
  parameter int P_WIDTH     = 30
) (
  input  logic                         ap_clk,
  input  logic                         ap_rst_n,
  input  logic                         cfg_enable,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*A_WIDTH-1:0]   req_a,
  input  logic [NUM_REQ*B_WIDTH-1:0]   req_b,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [ID_WIDTH-1:0]          rsp_id,
  output logic [P_WIDTH-1:0]           rsp_p,
  output logic                         busy
);

  logic [ID_WIDTH-1:0]     rr_ptr;
  logic [ID_WIDTH-1:0]     gnt;
  logic [ID_WIDTH-1:0]     ptr_next;
  logic                    found;
  logic                    pipe_en;
  logic                    accept;
  logic [A_WIDTH-1:0]      a_sel;
  logic [B_WIDTH-1:0]      b_sel;
  logic signed [P_WIDTH-1:0] prod_new;

  logic [MUL_LATENCY-1:0]  vld_q;
  logic [ID_WIDTH-1:0]     id_q [MUL_LATENCY];
  logic [P_WIDTH-1:0]      p_q  [MUL_LATENCY];

  // A held response freezes every stage, so nothing may enter.
  assign pipe_en = !(rsp_valid && !rsp_ready);

  // First valid requester at or after rr_ptr, wrapping.
  always_comb begin
    int idx;
    idx   = 0;
    gnt   = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        gnt   = ID_WIDTH'(idx);
      end
    end
  end

  assign accept   = found & cfg_enable & pipe_en & ap_rst_n;
  assign req_ready = accept ? (NUM_REQ'(1) << gnt) : '0;
  assign ptr_next = ID_WIDTH'((int'(gnt) + 1) % NUM_REQ);

  assign a_sel = req_a[int'(gnt)*A_WIDTH +: A_WIDTH];
  assign b_sel = req_b[int'(gnt)*B_WIDTH +: B_WIDTH];

  // a is zero-extended, b sign-extended; the full-width product is
  // exact. Later stages only carry the result, so synthesis can
  // retime the multiplier across them.
  assign prod_new = P_WIDTH'($signed({1'b0, a_sel})) *
                    P_WIDTH'($signed(b_sel));

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      rr_ptr <= '0;
      vld_q  <= '0;
      for (int i = 0; i < MUL_LATENCY; i++) begin
        id_q[i] <= '0;
        p_q[i]  <= '0;
      end
    end else if (pipe_en) begin
      vld_q[0] <= accept;
      if (accept) begin
        id_q[0] <= gnt;
        p_q[0]  <= prod_new;
        rr_ptr  <= ptr_next;
      end
      for (int i = 1; i < MUL_LATENCY; i++) begin
        vld_q[i] <= vld_q[i-1];
        id_q[i]  <= id_q[i-1];
        p_q[i]   <= p_q[i-1];
      end
    end
  end

  assign rsp_valid = vld_q[MUL_LATENCY-1];
  assign rsp_id    = id_q[MUL_LATENCY-1];
  assign rsp_p     = p_q[MUL_LATENCY-1];
  assign busy      = |vld_q;

endmodule

// File: tb/tb_xillybus_wrapper_mul_arbiter.sv
// Bench for xillybus_wrapper_mul_arbiter: directed steps plus random
// traffic checked against an in-order scoreboard model.
module tb_xillybus_wrapper_mul_arbiter;
  localparam int N   = 4;
  localparam int IDW = 2;
  localparam int L   = 3;
  localparam int AW  = 15;
  localparam int BW  = 15;
  localparam int PW  = 30;

  logic            ap_clk = 1'b0;
  logic            ap_rst_n = 1'b0;
  logic            cfg_enable = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_ready;
  logic [N*AW-1:0] req_a = '0;
  logic [N*BW-1:0] req_b = '0;
  logic            rsp_valid;
  logic            rsp_ready = 1'b1;
  logic [IDW-1:0]  rsp_id;
  logic [PW-1:0]   rsp_p;
  logic            busy;

  xillybus_wrapper_mul_arbiter #(
    .NUM_REQ(N), .ID_WIDTH(IDW), .MUL_LATENCY(L),
    .A_WIDTH(AW), .B_WIDTH(BW), .P_WIDTH(PW)
  ) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .cfg_enable(cfg_enable),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_p(rsp_p), .busy(busy)
  );

  always #5 ap_clk = ~ap_clk;

  int total = 0;
  int bad = 0;

  typedef struct {
    int          id;
    logic [PW-1:0] p;
    int          prog;
  } ent_t;

  ent_t         q[$];
  int           ptr = 0;
  logic [N-1:0] dut_ready;

  function automatic logic [PW-1:0] ref_mul(logic [AW-1:0] a,
                                            logic [BW-1:0] b);
    longint sa, sb, pr;
    sa = longint'(a);
    sb = b[BW-1] ? longint'(b) - (longint'(1) << BW) : longint'(b);
    pr = sa * sb;
    return pr[PW-1:0];
  endfunction

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clock: check outputs against the model, cross the edge,
  // advance the model. Entered and left at the falling edge.
  task automatic cycle();
    logic         ev, en;
    logic [N-1:0] er;
    int           g, idx;
    #1;
    ev = q.size() > 0 && q[0].prog >= L - 1;
    en = !(ev && !rsp_ready);
    g = -1;
    for (int k = 0; k < N; k++) begin
      idx = (ptr + k) % N;
      if (g < 0 && req_valid[idx]) g = idx;
    end
    er = (g >= 0 && cfg_enable && en && ap_rst_n) ? (N'(1) << g) : '0;
    dut_ready = req_ready;
    chk("rsp_valid", 64'(rsp_valid), 64'(ev));
    if (ev) begin
      chk("rsp_id", 64'(rsp_id), 64'(q[0].id));
      chk("rsp_p", 64'(rsp_p), 64'(q[0].p));
    end
    chk("req_ready", 64'(req_ready), 64'(er));
    chk("busy", 64'(busy), 64'(q.size() != 0));
    @(posedge ap_clk);
    if (!ap_rst_n) begin
      q.delete();
      ptr = 0;
    end else begin
      if (ev && rsp_ready) void'(q.pop_front());
      if (en)
        for (int i = 0; i < q.size(); i++) q[i].prog++;
      if (er != '0) begin
        q.push_back(ent_t'{id: g,
                           p: ref_mul(req_a[g*AW +: AW], req_b[g*BW +: BW]),
                           prog: 0});
        ptr = (g + 1) % N;
      end
    end
    @(negedge ap_clk);
  endtask

  task automatic rand_ops();
    req_a = (N*AW)'({$urandom(), $urandom()});
    req_b = (N*BW)'({$urandom(), $urandom()});
  endtask

  task automatic drain(string tag);
    int n;
    req_valid = '0;
    rsp_ready = 1'b1;
    n = 0;
    while (q.size() > 0 && n < 40) begin
      cycle();
      n++;
    end
    chk(tag, 64'(busy), 64'(0));
  endtask

  task automatic issue(int r, logic [AW-1:0] a, logic [BW-1:0] b);
    req_valid = N'(1) << r;
    req_a[r*AW +: AW] = a;
    req_b[r*BW +: BW] = b;
    cycle();
    req_valid = '0;
  endtask

  task automatic wait_rsp(output logic [PW-1:0] p, output bit ok);
    ok = 1'b0;
    p = '0;
    for (int i = 0; i < 30 && !ok; i++) begin
      if (rsp_valid && rsp_ready) begin
        p = rsp_p;
        ok = 1'b1;
      end
      cycle();
    end
  endtask

  logic [AW-1:0] ta [3];
  logic [BW-1:0] tb [3];
  logic [PW-1:0] tp [3];

  initial begin
    logic [PW-1:0] p, p0;
    logic [IDW-1:0] id0;
    bit ok;
    int n;

    ap_rst_n = 1'b0;
    repeat (2) @(posedge ap_clk);
    @(negedge ap_clk);
    cycle();
    chk("rst_valid", 64'(rsp_valid), 64'(0));
    chk("rst_id", 64'(rsp_id), 64'(0));
    chk("rst_p", 64'(rsp_p), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    ap_rst_n = 1'b1;
    cfg_enable = 1'b1;

    // single op and its latency
    issue(0, 15'd3, 15'h7FFB);
    n = 0;
    while (!rsp_valid && n < 20) begin
      cycle();
      n++;
    end
    chk("t1_lat", 64'(n), 64'(L - 1));
    chk("t1_id", 64'(rsp_id), 64'(0));
    chk("t1_p", 64'(rsp_p), 64'(30'h3FFFFFF1));
    cycle();

    // operand extremes
    ta[0] = 15'h7FFF; tb[0] = 15'h7FFF; tp[0] = 30'h3FFF8001;
    ta[1] = 15'h7FFF; tb[1] = 15'h4000; tp[1] = 30'h20004000;
    ta[2] = 15'h0000; tb[2] = 15'h5A5A; tp[2] = 30'h0;
    for (int i = 0; i < 3; i++) begin
      issue(2, ta[i], tb[i]);
      wait_rsp(p, ok);
      chk("t2_seen", 64'(ok), 64'(1));
      chk("t2_p", 64'(p), 64'(tp[i]));
    end
    drain("t2_drain");

    // round-robin from reset with all requesters valid
    ap_rst_n = 1'b0;
    cycle();
    ap_rst_n = 1'b1;
    req_valid = '1;
    for (int i = 0; i < 12; i++) begin
      rand_ops();
      cycle();
      chk("t3_grant", 64'(dut_ready), 64'(N'(1) << (i % N)));
    end

    // back-pressure on a full pipeline
    rsp_ready = 1'b0;
    p0 = rsp_p;
    id0 = rsp_id;
    for (int i = 0; i < 5; i++) begin
      rand_ops();
      cycle();
      chk("t4_ready", 64'(dut_ready), 64'(0));
      chk("t4_hold_p", 64'(rsp_p), 64'(p0));
      chk("t4_hold_id", 64'(rsp_id), 64'(id0));
    end
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rand_ops();
      cycle();
    end
    drain("t4_drain");

    // reset with three ops in flight
    req_valid = 4'b1011;
    for (int i = 0; i < 3; i++) begin
      rand_ops();
      cycle();
    end
    req_valid = '0;
    ap_rst_n = 1'b0;
    cycle();
    chk("t5_valid", 64'(rsp_valid), 64'(0));
    chk("t5_busy", 64'(busy), 64'(0));
    ap_rst_n = 1'b1;
    req_valid = '1;
    rand_ops();
    cycle();
    chk("t5_grant", 64'(dut_ready), 64'(1));
    drain("t5_drain");

    // disable with ops in flight, then re-enable
    req_valid = 4'b0001;
    rand_ops();
    cycle();
    cycle();
    cfg_enable = 1'b0;
    req_valid = 4'b0010;
    n = 0;
    while (q.size() > 0 && n < 20) begin
      cycle();
      chk("t6_noready", 64'(dut_ready), 64'(0));
      n++;
    end
    chk("t6_idle", 64'(busy), 64'(0));
    cfg_enable = 1'b1;
    cycle();
    chk("t6_grant", 64'(dut_ready), 64'(4'b0010));
    drain("t6_drain");

    // random traffic
    for (int i = 0; i < 400; i++) begin
      req_valid = N'($urandom());
      rsp_ready = ($urandom() % 4) != 0;
      cfg_enable = ($urandom() % 8) != 0;
      rand_ops();
      cycle();
    end
    cfg_enable = 1'b1;
    drain("rand_drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
